// File: rtl/tcdm_2to1_rr_arbiter_pkg.sv
// Shared types for the 2:1 TCDM round-robin arbiter: port ids, request/response bundles, FSM states.
// Pure declarations, no logic.
package tcdm_2to1_rr_arbiter_pkg;

    localparam int unsigned NUM_MST         = 2;
    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

    typedef logic port_id_t;

    typedef struct packed {
        logic [TCDM_ADDR_WIDTH-1:0] add;
        logic                       wen;
        logic [TCDM_DATA_WIDTH-1:0] wdata;
        logic [TCDM_BE_WIDTH-1:0]   be;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DATA_WIDTH-1:0] rdata;
        logic                       opc;
    } tcdm_rsp_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/tcdm_2to1_rr_arbiter_if.sv
// N-wide TCDM/LINT port bundle; response data/opc are shared across all N lanes.
// master drives requests, slave drives grants and responses.
interface tcdm_2to1_rr_arbiter_if #(
    parameter int unsigned N          = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic [N-1:0]                 req;
    logic [N-1:0][ADDR_WIDTH-1:0] add;
    logic [N-1:0]                 wen;
    logic [N-1:0][DATA_WIDTH-1:0] wdata;
    logic [N-1:0][BE_WIDTH-1:0]   be;
    logic [N-1:0]                 gnt;
    logic [N-1:0]                 r_valid;
    logic [DATA_WIDTH-1:0]        r_rdata;
    logic                         r_opc;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata, r_opc
    );
endinterface

// File: rtl/tcdm_2to1_rr_arbiter_fifo.sv
// Generic synchronous FIFO, no fall-through: data_o shows the head, push/pop take effect at the clock edge.
// Push when full and pop when empty are ignored; usage_o is the exact occupancy 0..DEPTH.
module tcdm_2to1_rr_arbiter_fifo #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt == CNT_W'(DEPTH));
    assign empty_o = (cnt == '0);
    assign usage_o = cnt;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/tcdm_2to1_rr_arbiter.sv
// Round-robin 2:1 TCDM merge with request locking and an origin FIFO steering in-order responses back.
// Zero-latency request/response paths; new grants stall while MAX_OUTST requests are unanswered.
module tcdm_2to1_rr_arbiter
    import tcdm_2to1_rr_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tcdm_2to1_rr_arbiter_if.slave   s_bus,
    tcdm_2to1_rr_arbiter_if.master  m_bus,
    output logic                    err_o
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    arb_state_e            state_q, state_d;
    port_id_t              locked_id_q, locked_id_d;
    port_id_t              rr_ptr_q, rr_ptr_d;
    port_id_t              sel;
    port_id_t              head;
    logic                  req_live, m_req, hs, full, empty, pop, err_q;
    logic [CNT_W-1:0]      usage;
    logic [NUM_MST-1:0]    s_gnt, s_r_valid;
    logic [ADDR_WIDTH-1:0] sel_add;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    always_comb begin
        sel = rr_ptr_q;
        if (state_q == LOCKED)          sel = locked_id_q;
        else if (s_bus.req == 2'b01)    sel = 1'b0;
        else if (s_bus.req == 2'b10)    sel = 1'b1;
    end

    // A locked master that withdraws its request must not let the other master slip in this cycle.
    assign req_live = (state_q == LOCKED) ? s_bus.req[locked_id_q] : |s_bus.req;
    assign full     = (usage == CNT_W'(MAX_OUTST));
    assign m_req    = req_live & ~full;
    assign hs       = m_req & m_bus.gnt[0];

    assign sel_add   = s_bus.add[sel];
    assign sel_wdata = s_bus.wdata[sel];
    assign sel_be    = s_bus.be[sel];

    assign m_bus.req[0]   = m_req;
    assign m_bus.add[0]   = sel_add;
    assign m_bus.wen[0]   = s_bus.wen[sel];
    assign m_bus.wdata[0] = sel_wdata;
    assign m_bus.be[0]    = sel_be;

    always_comb begin
        s_gnt      = '0;
        s_gnt[sel] = hs;
    end
    assign s_bus.gnt = s_gnt;

    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (hs) begin
            state_d  = IDLE;
            rr_ptr_d = ~sel;
        end else if (m_req) begin
            state_d     = LOCKED;
            locked_id_d = sel;
        end else if (state_q == LOCKED) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            locked_id_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    tcdm_2to1_rr_arbiter_fifo #(
        .DATA_WIDTH (1),
        .DEPTH      (MAX_OUTST)
    ) i_origin_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  (sel),
        .push_i  (hs),
        .data_o  (head),
        .pop_i   (pop)
    );

    assign pop = m_bus.r_valid[0] & ~empty;

    always_comb begin
        s_r_valid       = '0;
        s_r_valid[head] = pop;
    end
    assign rsp_rdata     = m_bus.r_rdata;
    assign s_bus.r_valid = s_r_valid;
    assign s_bus.r_rdata = rsp_rdata;
    assign s_bus.r_opc   = m_bus.r_opc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                         err_q <= 1'b0;
        else if (m_bus.r_valid[0] && empty)  err_q <= 1'b1;
    end
    assign err_o = err_q;
endmodule
